// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : FSM states and output-geometry helpers for conv_sequencer.
// Build option: CONV_SEQ_STRIDE2_EN selects stride-2 output geometry.
// Revision : 1.0
// ============================================================================
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } conv_state_e;

`ifdef CONV_SEQ_STRIDE2_EN
  localparam int CONV_STRIDE = 2;
`else
  localparam int CONV_STRIDE = 1;
`endif

  function automatic int conv_taps(input int k);
    return k * k;
  endfunction

  function automatic int conv_out_dim(input int in_dim, input int k);
    return (in_dim - k) / CONV_STRIDE + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_pos_counter.sv
`default_nettype none
// ============================================================================
// conv_pos_counter : two-level inner/outer wrap counter with last flag.
// Revision : 1.0
// ============================================================================
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int INNER_N = 3,
  parameter int OUTER_N = 3,
  parameter int W       = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] inner,
  output logic [W-1:0] outer,
  output logic [W-1:0] inner_nxt,
  output logic [W-1:0] outer_nxt,
  output logic         last
);

  logic [W-1:0] inner_q, inner_d;
  logic [W-1:0] outer_q, outer_d;
  logic         inner_wrap;
  logic         outer_wrap;

  always_comb begin
    inner_wrap = (inner_q == W'(INNER_N - 1));
    outer_wrap = (outer_q == W'(OUTER_N - 1));
    inner_d    = inner_q;
    outer_d    = outer_q;
    if (en) begin
      if (inner_wrap) begin
        inner_d = '0;
        outer_d = outer_wrap ? '0 : outer_q + W'(1);
      end else begin
        inner_d = inner_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  // The _nxt outputs let a caller register addresses for the value being stepped into.
  assign inner     = inner_q;
  assign outer     = outer_q;
  assign inner_nxt = inner_d;
  assign outer_nxt = outer_d;
  assign last      = inner_wrap && outer_wrap;

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
// conv_sequencer : address/strobe sequencer for one convolution layer.
// Build option: CONV_SEQ_STRIDE2_EN selects stride-2 output geometry.
// Revision : 1.0
// ============================================================================
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IN_W    = 10,
  parameter int IN_H    = 10,
  parameter int K       = 3,
  parameter int MEM_LAT = 1,
  parameter int AW      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] fm_row,
  output logic [AW-1:0] fm_col,
  output logic [3:0]    w_idx,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_i,
  output logic [AW-1:0] out_j
);

  localparam int TAPS  = conv_taps(K);
  localparam int OUT_W = conv_out_dim(IN_W, K);
  localparam int OUT_H = conv_out_dim(IN_H, K);
  localparam int DW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  conv_state_e        state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic               last_tap_q, last_tap_d;
  logic               out_valid_q, out_valid_d;
  logic [AW-1:0]      fm_row_q, fm_row_d;
  logic [AW-1:0]      fm_col_q, fm_col_d;
  logic [3:0]         w_idx_q, w_idx_d;
  logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [MEM_LAT-1:0] en_pipe_q, en_pipe_d;
  logic [MEM_LAT-1:0] clr_pipe_q, clr_pipe_d;

  logic               issue;
  logic               pos_en;
  logic [AW-1:0]      tap_c, tap_r, tap_c_nxt_unused, tap_r_nxt_unused;
  logic [AW-1:0]      pos_i, pos_j, pos_i_nxt, pos_j_nxt;
  logic               tap_last, pos_last;

  conv_pos_counter #(
    .INNER_N (K),
    .OUTER_N (K),
    .W       (AW)
  ) u_tap_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (issue),
    .inner     (tap_c),
    .outer     (tap_r),
    .inner_nxt (tap_c_nxt_unused),
    .outer_nxt (tap_r_nxt_unused),
    .last      (tap_last)
  );

  conv_pos_counter #(
    .INNER_N (OUT_W),
    .OUTER_N (OUT_H),
    .W       (AW)
  ) u_pos_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (pos_en),
    .inner     (pos_i),
    .outer     (pos_j),
    .inner_nxt (pos_i_nxt),
    .outer_nxt (pos_j_nxt),
    .last      (pos_last)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    drain_cnt_d = drain_cnt_q;
    issue       = 1'b0;
    pos_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = READ;
          issue   = 1'b1;
        end
      end
      READ: begin
        if (last_tap_q) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DW'(MEM_LAT - 1)) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      EMIT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          pos_en      = 1'b1;
          if (pos_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            issue   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A tap issued on the handshake edge belongs to the position being stepped into.
  always_comb begin
    rd_en_d    = issue;
    last_tap_d = issue && tap_last;
    fm_row_d   = fm_row_q;
    fm_col_d   = fm_col_q;
    w_idx_d    = w_idx_q;
    if (issue) begin
      fm_row_d = AW'(pos_j_nxt * CONV_STRIDE) + tap_r;
      fm_col_d = AW'(pos_i_nxt * CONV_STRIDE) + tap_c;
      w_idx_d  = 4'(int'(tap_r) * K + int'(tap_c));
    end
  end

  generate
    if (MEM_LAT == 1) begin : g_pipe_single
      always_comb begin
        en_pipe_d  = rd_en_q;
        clr_pipe_d = rd_en_q && (w_idx_q == 4'd0);
      end
    end else begin : g_pipe_multi
      always_comb begin
        en_pipe_d  = {en_pipe_q[MEM_LAT-2:0], rd_en_q};
        clr_pipe_d = {clr_pipe_q[MEM_LAT-2:0], rd_en_q && (w_idx_q == 4'd0)};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      last_tap_q  <= 1'b0;
      out_valid_q <= 1'b0;
      fm_row_q    <= '0;
      fm_col_q    <= '0;
      w_idx_q     <= '0;
      drain_cnt_q <= '0;
      en_pipe_q   <= '0;
      clr_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      last_tap_q  <= last_tap_d;
      out_valid_q <= out_valid_d;
      fm_row_q    <= fm_row_d;
      fm_col_q    <= fm_col_d;
      w_idx_q     <= w_idx_d;
      drain_cnt_q <= drain_cnt_d;
      en_pipe_q   <= en_pipe_d;
      clr_pipe_q  <= clr_pipe_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign fm_row    = fm_row_q;
  assign fm_col    = fm_col_q;
  assign w_idx     = w_idx_q;
  assign mac_en    = en_pipe_q[MEM_LAT-1];
  assign mac_clr   = clr_pipe_q[MEM_LAT-1];
  assign out_valid = out_valid_q;
  assign out_i     = pos_i;
  assign out_j     = pos_j;

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_conv_sequencer : self-checking bench for conv_sequencer.
// Build option: CONV_SEQ_STRIDE2_EN switches the expected geometry to stride 2.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_conv_sequencer;

  localparam int IN_W    = 10;
  localparam int IN_H    = 10;
  localparam int K       = 3;
  localparam int MEM_LAT = 1;
  localparam int AW      = 7;
`ifdef CONV_SEQ_STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int OW    = (IN_W - K) / S + 1;
  localparam int OH    = (IN_H - K) / S + 1;
  localparam int N     = OW * OH;
  localparam int TAPS  = K * K;
  localparam int PER   = TAPS + MEM_LAT + 1;
  localparam int LASTC = N * PER;
  localparam int LR    = S * (OH - 1) + K - 1;
  localparam int LC    = S * (OW - 1) + K - 1;
  localparam int VW    = 6 + 4 * AW + 4;
  localparam int MAXC  = 8192;

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    int   c;
    logic b, d, r;
    int   row, col, w;
    logic m, cl, v;
    int   oi, oj;
  } vec_rec_t;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic          busy, done, rd_en, mac_en, mac_clr, out_valid;
  logic [AW-1:0] fm_row, fm_col, out_i, out_j;
  logic [3:0]    w_idx;

  conv_sequencer #(
    .IN_W(IN_W), .IN_H(IN_H), .K(K), .MEM_LAT(MEM_LAT), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .fm_row(fm_row), .fm_col(fm_col), .w_idx(w_idx),
    .mac_en(mac_en), .mac_clr(mac_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_i(out_i), .out_j(out_j)
  );

  always #5 clk = ~clk;

  int   n_checks, n_fail, cyc, t0, done_cyc;
  bit   checking;
  bit   m_active, m_done;
  int   m_p, m_rs, m_row, m_col, m_w;
  bit   exp_rd  [MAXC];
  bit   exp_clr [MAXC];
  vec_t snap    [MAXC];
  vec_rec_t tbl [15];

  function automatic vec_t pack(logic b, logic d, logic r, int row, int col, int w,
                                logic m, logic c, logic v, int oi, int oj);
    return {b, d, r, AW'(row), AW'(col), 4'(w), m, c, v, AW'(oi), AW'(oj)};
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Timeline model: each position reads for TAPS cycles from m_rs, waits MEM_LAT, then emits.
  task automatic model_cycle();
    int   off, tap, oi, oj;
    bit   e_rd, e_v, e_m, e_c, was_done;
    vec_t e, act;
    off  = cyc - m_rs;
    e_rd = m_active && off >= 0 && off < TAPS;
    tap  = e_rd ? off : 0;
    if (e_rd) begin
      m_row = S * (m_p / OW) + tap / K;
      m_col = S * (m_p % OW) + tap % K;
      m_w   = tap;
    end
    e_v = m_active && off >= TAPS + MEM_LAT;
    oi  = m_active ? m_p % OW : 0;
    oj  = m_active ? m_p / OW : 0;
    exp_rd[cyc]  = e_rd;
    exp_clr[cyc] = e_rd && tap == 0;
    e_m = (cyc >= MEM_LAT) ? exp_rd[cyc-MEM_LAT]  : 1'b0;
    e_c = (cyc >= MEM_LAT) ? exp_clr[cyc-MEM_LAT] : 1'b0;
    e   = pack(m_active, m_done, e_rd, m_row, m_col, m_w, e_m, e_c, e_v, oi, oj);
    act = {busy, done, rd_en, fm_row, fm_col, w_idx, mac_en, mac_clr, out_valid, out_i, out_j};
    snap[cyc] = act;
    if (done === 1'b1) done_cyc = cyc;
    if (checking) check("cycle", act, e);

    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_row    = 0;
      m_col    = 0;
      m_w      = 0;
      for (int i = cyc - MEM_LAT + 1; i <= cyc; i++) begin
        if (i >= 0) begin
          exp_rd[i]  = 1'b0;
          exp_clr[i] = 1'b0;
        end
      end
      checking = 1'b1;
    end else if (!m_active) begin
      was_done = m_done;
      m_done   = 1'b0;
      if (start && !was_done) begin
        m_active = 1'b1;
        m_p      = 0;
        m_rs     = cyc + 1;
      end
    end else begin
      m_done = 1'b0;
      if (e_v && out_ready) begin
        m_p++;
        if (m_p == N) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_rs = cyc + 1;
        end
      end
    end
  endtask

  task automatic tick(input logic s, input logic r, input logic rs);
    start     = s;
    out_ready = r;
    rst       = rs;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_layer(input int len, input int stall_at, input int stall_len,
                           input int pulse_at, input int rst_at);
    t0       = cyc;
    done_cyc = -1;
    for (int i = 0; i < len; i++)
      tick((i == 0) || (i == pulse_at), !(i >= stall_at && i < stall_at + stall_len), i == rst_at);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph, hs;
    n_checks = 0; n_fail = 0; cyc = 0; t0 = 0; done_cyc = -1;
    checking = 1'b0; m_active = 1'b0; m_done = 1'b0;
    m_p = 0; m_rs = 0; m_row = 0; m_col = 0; m_w = 0;
    start = 1'b0; out_ready = 1'b0; rst = 1'b1;

    tbl[0]  = '{0,         0, 0, 0, 0,  0,     0,        0, 0, 0, 0,      0};
    tbl[1]  = '{1,         1, 0, 1, 0,  0,     0,        0, 0, 0, 0,      0};
    tbl[2]  = '{2,         1, 0, 1, 0,  1,     1,        1, 1, 0, 0,      0};
    tbl[3]  = '{3,         1, 0, 1, 0,  2,     2,        1, 0, 0, 0,      0};
    tbl[4]  = '{4,         1, 0, 1, 1,  0,     3,        1, 0, 0, 0,      0};
    tbl[5]  = '{9,         1, 0, 1, 2,  2,     8,        1, 0, 0, 0,      0};
    tbl[6]  = '{10,        1, 0, 0, 2,  2,     8,        1, 0, 0, 0,      0};
    tbl[7]  = '{11,        1, 0, 0, 2,  2,     8,        0, 0, 1, 0,      0};
    tbl[8]  = '{12,        1, 0, 1, 0,  S,     0,        0, 0, 0, 1,      0};
    tbl[9]  = '{13,        1, 0, 1, 0,  S + 1, 1,        1, 1, 0, 1,      0};
    tbl[10] = '{14,        1, 0, 1, 0,  S + 2, 2,        1, 0, 0, 1,      0};
    tbl[11] = '{LASTC,     1, 0, 0, LR, LC,    TAPS - 1, 0, 0, 1, OW - 1, OH - 1};
    tbl[12] = '{LASTC + 1, 0, 1, 0, LR, LC,    TAPS - 1, 0, 0, 0, 0,      0};
    tbl[13] = '{LASTC + 2, 0, 0, 0, LR, LC,    TAPS - 1, 0, 0, 0, 0,      0};
    tbl[14] = '{LASTC + 3, 1, 0, 1, 0,  0,     0,        0, 0, 0, 0,      0};

    @(posedge clk);
    #1;
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b1, 1'b0);

    // Full layer, then start on the done cycle (ignored) and the cycle after (accepted).
    t0 = cyc; done_cyc = -1;
    tick(1'b1, 1'b1, 1'b0);
    repeat (LASTC) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    check_int("done_cycle_basic", done_cyc - t0, LASTC + 1);
    for (int i = 0; i < 15; i++)
      check($sformatf("table_c%0d", tbl[i].c), snap[t0 + tbl[i].c],
            pack(tbl[i].b, tbl[i].d, tbl[i].r, tbl[i].row, tbl[i].col, tbl[i].w,
                 tbl[i].m, tbl[i].cl, tbl[i].v, tbl[i].oi, tbl[i].oj));

    // Back-pressure for 5 cycles at position (3,2).
    repeat (2) tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    ph = 2 * OW + 3;
    hs = (ph + 1) * PER;
    run_layer(LASTC + 8, hs, 5, -1, -1);
    check_int("done_cycle_stall", done_cyc - t0, LASTC + 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("stall_hold_%0d", i), snap[t0 + hs + i],
            pack(1, 0, 0, S * 2 + K - 1, S * 3 + K - 1, TAPS - 1, 0, 0, 1, 3, 2));

    // Start pulse while busy.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    run_layer(LASTC + 4, -1, 0, 50, -1);
    check_int("done_cycle_busy_start", done_cyc - t0, LASTC + 1);

    // Reset during READ, then a clean layer.
    tick(1'b0, 1'b1, 1'b0);
    run_layer(40, -1, 0, -1, 30);
    check("reset_zero", snap[t0 + 31], '0);
    check_int("no_done_after_reset", done_cyc, -1);
    run_layer(LASTC + 3, -1, 0, -1, -1);
    check_int("done_cycle_after_reset", done_cyc - t0, LASTC + 1);

    // Random back-pressure, start pulses and rare resets.
    for (int i = 0; i < 2000; i++)
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1499) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_sequencer.md
# conv_sequencer

Control sequencer for one convolution layer. On `start` it walks every output position, issues the K×K feature-map/weight reads per position and drives the MAC accumulator strobes. It then presents each finished result position to the downstream writer over a valid/ready handshake. It sits between the layer-level top controller and the feature memory, weight ROM and MAC unit; it carries no data, only addresses and strobes.

## Interface
- `IN_W`, default 10: input feature-map width in pixels.
- `IN_H`, default 10: input feature-map height in pixels.
- `K`, default 3: square kernel size.
- `MEM_LAT`, default 1: read latency of the feature memory and weight ROM in cycles; must be ≥1.
- `AW`, default 7: width of row/column/position outputs.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to process one full layer.
- `busy` out 1: high whenever the FSM is not IDLE.
- `done` out 1: one-cycle pulse after the final output handshake.
- `rd_en` out 1: feature/weight read strobe.
- `fm_row` out AW: feature-map row address.
- `fm_col` out AW: feature-map column address.
- `w_idx` out 4: weight tap index, 0..K*K-1.
- `mac_en` out 1: accumulate enable.
- `mac_clr` out 1: with `mac_en`, load the product instead of adding it.
- `out_valid` out 1: the accumulator holds the result for (`out_i`, `out_j`).
- `out_ready` in 1: downstream accepts the result.
- `out_i` out AW: output column (inner loop).
- `out_j` out AW: output row (outer loop).

## Operation
- Output grid: OUT_W = IN_W-K+1 and OUT_H = IN_H-K+1. Defaults give 8×8.
- Position order: `out_i` increments first. On `out_i` wrap to 0, `out_j` increments. After (OUT_W-1, OUT_H-1) the layer ends.
- States and transitions:
  - IDLE → READ on `start`.
  - READ → DRAIN after K*K cycles.
  - DRAIN → EMIT after MEM_LAT cycles.
  - EMIT → READ (next position) on `out_valid & out_ready`.
  - EMIT → IDLE after the last position, with `done`=1 in that first IDLE cycle.
- READ issues one tap per cycle with `rd_en`=1. Tap order is kr outer, kc inner.
  - `fm_row` = out_j+kr, `fm_col` = out_i+kc, `w_idx` = kr*K+kc.
  - All are registered, so address and `rd_en` appear together.
- `mac_en` is `rd_en` delayed by MEM_LAT cycles. `mac_clr` is high only with the first delayed tap (kr=kc=0) of each position.
- `out_valid` is high for all of EMIT. `out_i`/`out_j` stay stable in EMIT until the handshake completes. No reads are issued in EMIT.
- `start` while `busy` is ignored. `start` coinciding with `done` is ignored; `start` in the following cycle is accepted.
- `out_ready` outside EMIT has no effect.
- Reset (any state, including mid-layer) values, applied at the next edge:
  - FSM to IDLE.
  - All outputs 0, including `out_i`/`out_j`.
  - No `done` pulse.
  - MAC strobes still in the delay pipe are flushed.
- `fm_row`/`fm_col`/`w_idx` hold their last value when `rd_en`=0.

## Timing
Cycle numbers below assume defaults and `start` high in cycle 0.
- READ occupies cycles 1..9: `rd_en`=1, taps 0..8.
- `mac_en` is high in cycles 2..10; `mac_clr` is high in cycle 2.
- DRAIN is cycle 10; first `out_valid` is in cycle 11.
- Per-position period with `out_ready` held high: K*K+MEM_LAT+1 = 11 cycles.
- Final handshake is in cycle 64×11 = 704; `done`=1 and `busy`=0 in cycle 705.
- Each cycle of `out_ready`=0 in EMIT adds exactly one cycle.

## Configuration
- `CONV_SEQ_STRIDE2_EN` defined, stride 2:
  - OUT_W = (IN_W-K)/2+1 and OUT_H = (IN_H-K)/2+1.
  - `fm_row` = 2·out_j+kr, `fm_col` = 2·out_i+kc.
  - Defaults give a 4×4 grid.
- Not defined: stride 1 as above. Timing per position is unchanged in both cases.

## Structure
- Package `conv_pkg`:
  - FSM state enum (IDLE, READ, DRAIN, EMIT).
  - Tap count K*K.
  - OUT_W/OUT_H derivation function, stride-aware under the macro.
- Sub-module `conv_pos_counter`: two-level (inner/outer) counter with enable, synchronous reset and last-position flag. Instantiated once for (kc,kr) and once for (out_i,out_j).

## Test plan
- Reset then `start`, `out_ready`=1 → 64 handshakes in order (0,0),(1,0)…(7,7); `done` in cycle 705 only.
- First position → `rd_en` cycles 1..9, `fm_row`/`fm_col` sequence (0,0),(0,1),(0,2),(1,0)…(2,2), `mac_clr` only in cycle 2, `out_valid` in cycle 11.
- Hold `out_ready`=0 for 5 cycles at position (3,2) → `out_valid` and `out_i`=3/`out_j`=2 stable, no `rd_en`; `done` moves to cycle 710.
- Pulse `start` at cycle 50 while busy → no effect; output sequence and `done` timing identical to the first scenario.
- Assert `rst` at cycle 30 during READ → next cycle all outputs 0 and `busy`=0; no `mac_en` afterwards; a new `start` runs a clean layer.
- With `CONV_SEQ_STRIDE2_EN` → 16 outputs; position (1,0) reads `fm_col` 2..4; `done` in cycle 177.
